idwt_transpose_buf: RTL and testbench
=====================================

// Module: idwt_transpose_buf
// PURPOSE
//  Ping-pong 8x8 transpose buffer between the row pass and column pass of the 2D IDWT.
//  Collects N row words from the 1D row-IDWT stage (one row per beat, sample j in byte lane j)
//  and re-emits the same block as N column words, so the next 1D IDWT stage sees columns.
//  Two banks: one fills while the other drains, so streaming input is never stalled by draining.
// PARAMETERS
//  DW  8  bits per sample
//  N   8  block dimension (rows per block = columns per block = samples per word)
// PORTS
//  clk        in   1     system clock, all state updates on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_data    in   N*DW  row word; sample j (column j) = in_data[DW*j+DW-1 : DW*j]
//  in_valid   in   1     in_data valid (driven by upstream idwt_valid)
//  in_ready   out  1     buffer can accept a row this cycle
//  out_data   out  N*DW  column word; sample r (row r) in lane r
//  out_valid  out  1     out_data holds a valid column
//  out_ready  in   1     downstream accepts column this cycle
//  out_last   out  1     high with out_valid on column N-1 of a block
// BEHAVIOUR
//  - Storage: 2 banks x N x N samples, registers; contents not reset.
//  - State: wr_bank, rd_bank (1 bit each); wr_row, rd_col ($clog2(N) bits); full[1:0].
//  - Reset (async, rst_n=0): full=00, wr_bank=rd_bank=0, wr_row=rd_col=0;
//    in_ready=1 after reset is released, out_valid=0, out_last=0, out_data=0.
//  - Reset mid-operation discards any partial or undrained block; no output follows.
//  - Write: in_fire = in_valid & in_ready. in_ready = ~full[wr_bank] (combinational).
//    On in_fire: bank[wr_bank][wr_row] <= in_data; wr_row++.
//    When wr_row==N-1 on in_fire: wr_row<=0, full[wr_bank]<=1, wr_bank toggles.
//  - Read: out_valid = full[rd_bank]. out_data lane r = bank[rd_bank][r][rd_col] when
//    out_valid, else 0. out_last = out_valid & (rd_col==N-1).
//    out_fire = out_valid & out_ready: rd_col++; at rd_col==N-1: rd_col<=0,
//    full[rd_bank]<=0, rd_bank toggles.
//  - Latency: last row of a block accepted at edge k -> out_valid=1 in the cycle after edge k
//    (first column). Unstalled, N columns leave on N consecutive cycles.
//  - Backpressure: out_valid=1 with out_ready=0 holds out_data, out_last and rd_col stable.
//    Once accepted, a valid never drops before out_fire.
//  - Simultaneous events: a completing write to one bank and a completing read of the other
//    in the same cycle set and clear their own full bits independently. Neither event is lost.
//    wr_bank and rd_bank never address the same bank while it is both filling and full.
//  - Both banks full: in_ready=0 until the drain of rd_bank completes. in_ready rises the cycle
//    after the final out_fire, never combinationally from out_ready.
//  - in_valid while in_ready=0 is ignored; upstream must hold the row.
//  - No arithmetic on samples; width preserved bit-exact (DW bits in = DW bits out).
// TESTING
//  1 Fill one block, row r lane c = {r[3:0],c[3:0]}, out_ready=1 -> 8 columns;
//    column c lane r = {r,c}; out_last only on c=7; out_valid low afterwards.
//  2 16 rows back-to-back, out_ready=1 -> in_ready stays 1 throughout.
//    Block 0 columns appear during rows 8-15; block 1 columns follow with no gap.
//  3 out_ready=0, send 17 rows -> in_ready=0 after row 16; row 17 is held.
//    Raise out_ready -> 8 columns drain, then row 17 is accepted; its data lands in row 0.
//  4 Toggle out_ready every cycle during a drain -> out_data is stable while stalled.
//    Exactly 8 columns leave, in order 0..7.
//  5 Assert rst_n=0 after 5 rows, release, send 8 fresh rows.
//    -> No output from the partial block; fresh block transposed correctly.
//  6 Bank1 row 7 written in the same cycle as bank0 column 7 accepted.
//    -> full goes 01->10 in one edge; bank1 drains next with correct data.

Source files
------------

// File: rtl/idwt_transpose_buf.sv
// rtl/idwt_transpose_buf.sv - ping-pong NxN transpose buffer between IDWT row and column passes
//
// Purpose:
//   Accepts one row word per beat from the row-IDWT stage and, once a block of
//   N rows is complete, emits the same block as N column words for the column
//   pass. Two banks let one block fill while the previous one drains.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    row word, sample j (column j) in lane j
//   in_valid   row word valid
//   in_ready   buffer can take a row this cycle
//   out_data   column word, sample r (row r) in lane r; zero when out_valid is low
//   out_valid  a column is presented
//   out_ready  downstream takes the column this cycle
//   out_last   out_valid on column N-1 of a block

module idwt_transpose_buf #(
  parameter int DW = 8,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last
);

  localparam int            AW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  // Sample storage, indexed [bank][row][column]; contents are never reset.
  logic [DW-1:0] r_mem [2][N][N];

  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_row;
  logic [AW-1:0] r_rd_col;
  logic [1:0]    r_full;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_wr_done;
  logic          w_rd_done;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;

  // in_ready depends only on registered state, so a drain finishing this cycle
  // frees the bank for writing no earlier than the next cycle.
  assign in_ready   = ~r_full[r_wr_bank];
  assign out_valid  = r_full[r_rd_bank];
  assign out_last   = out_valid & (r_rd_col == LAST_IDX);

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_wr_done  = w_in_fire & (r_wr_row == LAST_IDX);
  assign w_rd_done  = w_out_fire & (r_rd_col == LAST_IDX);

  // A bank being written is never full and a bank being read is always full,
  // so set and clear can never target the same bank in one cycle.
  assign w_full_set = w_wr_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_clr = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= '0;
      r_rd_col  <= '0;
      r_full    <= 2'b00;
    end else begin
      if (w_in_fire) begin
        if (w_wr_done) begin
          r_wr_row  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row  <= r_wr_row + AW'(1);
        end
      end
      if (w_out_fire) begin
        if (w_rd_done) begin
          r_rd_col  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_col  <= r_rd_col + AW'(1);
        end
      end
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int c = 0; c < N; c++) begin
        r_mem[r_wr_bank][r_wr_row][c] <= in_data[DW*c +: DW];
      end
    end
  end

  // Column read: lane r picks row r of the draining bank at the current column.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int r = 0; r < N; r++) begin
        out_data[DW*r +: DW] = r_mem[r_rd_bank][r][r_rd_col];
      end
    end
  end

endmodule

// File: tb/tb_idwt_transpose_buf.sv
// tb/tb_idwt_transpose_buf.sv - directed self-checking bench for idwt_transpose_buf
module tb_idwt_transpose_buf;

  localparam int DW = 8;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  always #5 clk = ~clk;

  idwt_transpose_buf #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] rows_q[$];
  logic [63:0] out_log_data[$];
  logic        out_log_last[$];
  int          out_log_cyc[$];
  int          in_log_cyc[$];
  int          blocked_cnt;
  int          blocked_first;
  int          stall_cycles;
  int          stall_changes;
  bit          timed_out;

  // Row idx of a block: lane k = base + 16*idx + k
  function automatic logic [63:0] row_word(input logic [7:0] base, input int idx);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = base + 8'(16*idx) + 8'(k);
    return w;
  endfunction

  // Column idx of the same block: lane k = base + 16*k + idx
  function automatic logic [63:0] col_word(input logic [7:0] base, input int idx);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = base + 8'(16*k) + 8'(idx);
    return w;
  endfunction

  task automatic add_block(input logic [7:0] base);
    for (int r = 0; r < 8; r++) rows_q.push_back(row_word(base, r));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives queued rows and a ready pattern, logging every fire; stops when all
  // rows are sent and want_out columns were taken, or after max_cyc cycles.
  task automatic run(input int max_cyc, input int ready_from, input bit toggle, input int want_out);
    int          cyc;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    cyc = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    out_log_data.delete(); out_log_last.delete(); out_log_cyc.delete(); in_log_cyc.delete();
    blocked_cnt = 0; blocked_first = -1; stall_cycles = 0; stall_changes = 0;
    while (cyc < max_cyc && (rows_q.size() > 0 || out_log_data.size() < want_out)) begin
      @(negedge clk);
      in_valid  = (rows_q.size() > 0);
      in_data   = in_valid ? rows_q[0] : '0;
      out_ready = (cyc >= ready_from) && (!toggle || (cyc % 2 == 1));
      #1;
      if (in_valid && !in_ready) begin
        blocked_cnt++;
        if (blocked_first < 0) blocked_first = cyc;
      end
      if (in_valid && in_ready) begin
        in_log_cyc.push_back(cyc);
        void'(rows_q.pop_front());
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_changes++;
      if (out_valid && out_ready) begin
        out_log_data.push_back(out_data);
        out_log_last.push_back(out_last);
        out_log_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cycles++;
      prev_data = out_data;
      prev_last = out_last;
      cyc++;
    end
    timed_out = (rows_q.size() > 0 || out_log_data.size() < want_out);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
    n_checks++; if (out_data !== 64'h0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_block();
    do_reset();
    add_block(8'h00);
    run(60, 0, 1'b0, 8);
    n_checks++; if (timed_out) $display("FAIL single_timeout got %0d cols want 8", out_log_data.size()); else n_pass++;
    n_checks++; if (out_log_data.size() != 8) $display("FAIL single_count got %0d want 8", out_log_data.size()); else n_pass++;
    for (int k = 0; k < out_log_data.size() && k < 8; k++) begin
      n_checks++;
      if (out_log_data[k] !== col_word(8'h00, k))
        $display("FAIL single_col%0d got %h want %h", k, out_log_data[k], col_word(8'h00, k));
      else n_pass++;
      n_checks++;
      if (out_log_last[k] !== (k == 7))
        $display("FAIL single_last%0d got %b want %b", k, out_log_last[k], (k == 7));
      else n_pass++;
    end
    if (out_log_cyc.size() > 0 && in_log_cyc.size() == 8) begin
      n_checks++;
      if (out_log_cyc[0] != in_log_cyc[7] + 1)
        $display("FAIL single_latency got cycle %0d want %0d", out_log_cyc[0], in_log_cyc[7] + 1);
      else n_pass++;
    end
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_after got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_block(8'h00);
    add_block(8'h80);
    run(100, 0, 1'b0, 16);
    n_checks++; if (timed_out) $display("FAIL b2b_timeout got %0d cols want 16", out_log_data.size()); else n_pass++;
    n_checks++; if (blocked_cnt != 0) $display("FAIL b2b_in_ready_low got %0d cycles want 0", blocked_cnt); else n_pass++;
    for (int k = 0; k < out_log_data.size() && k < 16; k++) begin
      n_checks++;
      if (out_log_cyc[k] != 8 + k)
        $display("FAIL b2b_cycle%0d got %0d want %0d", k, out_log_cyc[k], 8 + k);
      else n_pass++;
      n_checks++;
      if (out_log_data[k] !== col_word((k < 8) ? 8'h00 : 8'h80, k % 8))
        $display("FAIL b2b_col%0d got %h want %h", k, out_log_data[k], col_word((k < 8) ? 8'h00 : 8'h80, k % 8));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure_full();
    logic [7:0] bases [3];
    bases[0] = 8'h00; bases[1] = 8'h80; bases[2] = 8'h40;
    do_reset();
    add_block(bases[0]);
    add_block(bases[1]);
    add_block(bases[2]);
    run(200, 20, 1'b0, 24);
    n_checks++; if (timed_out) $display("FAIL bp_timeout got %0d cols want 24", out_log_data.size()); else n_pass++;
    n_checks++; if (blocked_first != 16) $display("FAIL bp_first_blocked got %0d want 16", blocked_first); else n_pass++;
    n_checks++; if (blocked_cnt != 12) $display("FAIL bp_blocked_cycles got %0d want 12", blocked_cnt); else n_pass++;
    if (out_log_cyc.size() >= 8 && in_log_cyc.size() >= 17) begin
      n_checks++;
      if (out_log_cyc[0] != 20) $display("FAIL bp_first_out got %0d want 20", out_log_cyc[0]); else n_pass++;
      n_checks++;
      if (out_log_cyc[7] != 27) $display("FAIL bp_drain_end got %0d want 27", out_log_cyc[7]); else n_pass++;
      n_checks++;
      if (in_log_cyc[16] != 28) $display("FAIL bp_row17_accept got %0d want 28", in_log_cyc[16]); else n_pass++;
    end
    for (int k = 0; k < out_log_data.size() && k < 24; k++) begin
      n_checks++;
      if (out_log_data[k] !== col_word(bases[k/8], k % 8))
        $display("FAIL bp_col%0d got %h want %h", k, out_log_data[k], col_word(bases[k/8], k % 8));
      else n_pass++;
    end
  endtask

  task automatic test_toggle_stall();
    do_reset();
    add_block(8'h33);
    run(100, 0, 1'b1, 8);
    n_checks++; if (timed_out) $display("FAIL toggle_timeout got %0d cols want 8", out_log_data.size()); else n_pass++;
    n_checks++; if (stall_cycles != 8) $display("FAIL toggle_stall_cycles got %0d want 8", stall_cycles); else n_pass++;
    n_checks++; if (stall_changes != 0) $display("FAIL toggle_stall_stable got %0d changes want 0", stall_changes); else n_pass++;
    n_checks++; if (out_log_data.size() != 8) $display("FAIL toggle_count got %0d want 8", out_log_data.size()); else n_pass++;
    for (int k = 0; k < out_log_data.size() && k < 8; k++) begin
      n_checks++;
      if (out_log_data[k] !== col_word(8'h33, k) || out_log_cyc[k] != 9 + 2*k)
        $display("FAIL toggle_col%0d got %h@%0d want %h@%0d", k, out_log_data[k], out_log_cyc[k], col_word(8'h33, k), 9 + 2*k);
      else n_pass++;
    end
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL toggle_valid_after got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < 5; r++) rows_q.push_back(row_word(8'h55, r));
    run(50, 0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else n_pass++;
    add_block(8'h11);
    run(100, 0, 1'b0, 8);
    n_checks++; if (timed_out) $display("FAIL rstmid_timeout got %0d cols want 8", out_log_data.size()); else n_pass++;
    if (out_log_cyc.size() > 0) begin
      n_checks++;
      if (out_log_cyc[0] != 8) $display("FAIL rstmid_first_out got %0d want 8", out_log_cyc[0]); else n_pass++;
    end
    for (int k = 0; k < out_log_data.size() && k < 8; k++) begin
      n_checks++;
      if (out_log_data[k] !== col_word(8'h11, k))
        $display("FAIL rstmid_col%0d got %h want %h", k, out_log_data[k], col_word(8'h11, k));
      else n_pass++;
    end
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid_after got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    add_block(8'hA0);
    add_block(8'h05);
    run(100, 0, 1'b0, 16);
    n_checks++; if (timed_out) $display("FAIL simul_timeout got %0d cols want 16", out_log_data.size()); else n_pass++;
    if (out_log_cyc.size() == 16 && in_log_cyc.size() == 16) begin
      n_checks++;
      if (in_log_cyc[15] != 15 || out_log_cyc[7] != 15)
        $display("FAIL simul_same_cycle got row7@%0d col7@%0d want 15/15", in_log_cyc[15], out_log_cyc[7]);
      else n_pass++;
      n_checks++;
      if (out_log_cyc[8] != 16) $display("FAIL simul_bank1_start got %0d want 16", out_log_cyc[8]); else n_pass++;
      n_checks++;
      if (out_log_last[15] !== 1'b1) $display("FAIL simul_bank1_last got %b want 1", out_log_last[15]); else n_pass++;
    end
    for (int k = 8; k < out_log_data.size() && k < 16; k++) begin
      n_checks++;
      if (out_log_data[k] !== col_word(8'h05, k - 8))
        $display("FAIL simul_col%0d got %h want %h", k - 8, out_log_data[k], col_word(8'h05, k - 8));
      else n_pass++;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; rst_n = 1'b0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure_full();
    test_toggle_stall();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time %0t want completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
